pr_bus_arbiter: RTL and testbench

- Two-master arbiter and sequencer in front of the system bridge's processor-side port (PrAddr/PrWE/PrWD/PrRD).
- Shares the device bus (Timer0 at 0x7F00, Timer1 at 0x7F10) between the CPU data port (M0) and a secondary master (M1, DMA/debug).
- Grants round-robin and supports locked bursts.
- Each access is a registered single-word transaction with a fixed 2-cycle request-to-done latency.

---
 rtl/pr_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_pr_bus_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pr_bus_arbiter.sv
// Two-master round-robin arbiter in front of the bridge's processor-side port.
// Every access takes a fixed ACCESS + DONE pair; locked masters may chain beats.
module pr_bus_arbiter #(
    parameter int          MAX_BURST = 4,
    parameter logic [29:0] DEV_LO    = 30'h00001FC0,
    parameter logic [29:0] DEV_HI    = 30'h00001FC7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic        m0_we,
    input  logic [29:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic        m1_we,
    input  logic [29:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m1_rd,
    output logic        err,
    output logic [29:0] PrAddr,
    output logic        PrWE,
    output logic [31:0] PrWD,
    input  logic [31:0] PrRD
);

    // state    | meaning
    // S_IDLE   | bus free, arbitrate between requesters
    // S_ACCESS | latched transaction driven to bridge, PrRD captured
    // S_DONE   | completion pulse to owner, optional locked re-grant
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        rr_q, rr_d;
    logic        owner_q, owner_d;
    logic [3:0]  burst_q, burst_d;
    logic        we_q, we_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q, rd_d;

    logic        in_range;
    logic        arb_sel;
    logic        src;
    logic        own_req;
    logic        own_lock;
    logic        busy;

    assign in_range = (addr_q >= DEV_LO) && (addr_q <= DEV_HI);
    assign arb_sel  = (m0_req && m1_req) ? rr_q : m1_req;
    // In IDLE the arbiter picks the source; in DONE only the owner can re-latch.
    assign src      = (state_q == S_IDLE) ? arb_sel : owner_q;
    assign own_req  = owner_q ? m1_req  : m0_req;
    assign own_lock = owner_q ? m1_lock : m0_lock;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d = src;
                    we_d    = src ? m1_we   : m0_we;
                    addr_d  = src ? m1_addr : m0_addr;
                    wd_d    = src ? m1_wd   : m0_wd;
                    burst_d = 4'd1;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rd_d    = in_range ? PrRD : 32'h0;
                state_d = S_DONE;
            end
            S_DONE: begin
                rr_d = ~owner_q;
                if (own_lock && own_req && (burst_q < 4'(MAX_BURST))) begin
                    we_d    = src ? m1_we   : m0_we;
                    addr_d  = src ? m1_addr : m0_addr;
                    wd_d    = src ? m1_wd   : m0_wd;
                    burst_d = burst_q + 4'd1;
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            burst_q <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 30'h0;
            wd_q    <= 32'h0;
            rd_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
        end
    end

    assign busy    = (state_q == S_ACCESS) || (state_q == S_DONE);
    assign m0_gnt  = busy & ~owner_q;
    assign m1_gnt  = busy &  owner_q;
    assign m0_done = (state_q == S_DONE) & ~owner_q;
    assign m1_done = (state_q == S_DONE) &  owner_q;
    assign m0_rd   = m0_done ? rd_q : 32'h0;
    assign m1_rd   = m1_done ? rd_q : 32'h0;
    assign err     = (state_q == S_DONE) & ~in_range;
    assign PrAddr  = busy ? addr_q : 30'h0;
    assign PrWD    = busy ? wd_q : 32'h0;
    assign PrWE    = (state_q == S_ACCESS) & we_q & in_range;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Directed bench for pr_bus_arbiter: reset, single accesses, round-robin,
// locked burst, out-of-range access and reset during an access.
module tb_pr_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_lock, m0_we;
    logic [29:0] m0_addr;
    logic [31:0] m0_wd;
    logic        m0_gnt, m0_done;
    logic [31:0] m0_rd;
    logic        m1_req, m1_lock, m1_we;
    logic [29:0] m1_addr;
    logic [31:0] m1_wd;
    logic        m1_gnt, m1_done;
    logic [31:0] m1_rd;
    logic        err;
    logic [29:0] PrAddr;
    logic        PrWE;
    logic [31:0] PrWD;
    logic [31:0] PrRD;

    int n_chk  = 0;
    int n_fail = 0;

    pr_bus_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rd(m1_rd),
        .err(err), .PrAddr(PrAddr), .PrWE(PrWE), .PrWD(PrWD), .PrRD(PrRD)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        m0_req  = 1'b1; m0_lock = 1'b0; m0_we = 1'b0; m0_addr = 30'h1FC0; m0_wd = 32'h0;
        m1_req  = 1'b0; m1_lock = 1'b0; m1_we = 1'b0; m1_addr = 30'h0;    m1_wd = 32'h0;
        PrRD    = 32'h0BAD_CAFE;

        // reset held with m0_req asserted
        repeat (2) tick();
        chk_val("rst_m0_gnt", m0_gnt, 0);
        chk_val("rst_m1_gnt", m1_gnt, 0);
        chk_val("rst_m0_done", m0_done, 0);
        chk_val("rst_m0_rd", m0_rd, 0);
        chk_val("rst_err", err, 0);
        chk_val("rst_praddr", PrAddr, 0);
        chk_val("rst_prwe", PrWE, 0);
        chk_val("rst_prwd", PrWD, 0);
        reset = 1'b1;
        tick();
        chk_val("r1_m0_gnt", m0_gnt, 1);
        chk_val("r1_praddr", PrAddr, 30'h1FC0);
        chk_val("r1_m0_done", m0_done, 0);
        tick();
        chk_val("r2_m0_done", m0_done, 1);
        chk_val("r2_m0_rd", m0_rd, 32'h0BAD_CAFE);
        chk_val("r2_m1_rd", m1_rd, 0);
        m0_req = 1'b0;
        tick();
        chk_val("r3_m0_gnt", m0_gnt, 0);

        // M0 in-range write
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 30'h1FC1; m0_wd = 32'h0000_00FF;
        tick();
        chk_val("w_prwe_acc", PrWE, 1);
        chk_val("w_prwd", PrWD, 32'h0000_00FF);
        chk_val("w_praddr", PrAddr, 30'h1FC1);
        chk_val("w_m0_done_acc", m0_done, 0);
        tick();
        chk_val("w_prwe_done", PrWE, 0);
        chk_val("w_m0_done", m0_done, 1);
        chk_val("w_err", err, 0);
        chk_val("w_m1_done", m1_done, 0);
        chk_val("w_praddr_hold", PrAddr, 30'h1FC1);
        m0_req = 1'b0; m0_we = 1'b0;
        tick();
        chk_val("w_prwe_idle", PrWE, 0);

        // M1 read
        PrRD = 32'h1234_5678;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 30'h1FC5;
        tick();
        chk_val("r_m1_gnt", m1_gnt, 1);
        chk_val("r_m0_gnt", m0_gnt, 0);
        chk_val("r_prwe", PrWE, 0);
        tick();
        chk_val("r_m1_done", m1_done, 1);
        chk_val("r_m1_rd", m1_rd, 32'h1234_5678);
        chk_val("r_m0_rd", m0_rd, 0);
        chk_val("r_m0_done", m0_done, 0);
        m1_req = 1'b0;
        tick();
        chk_val("r_m1_rd_idle", m1_rd, 0);

        // simultaneous requests without lock alternate M0, M1, M0, M1
        m0_addr = 30'h1FC2; m1_addr = 30'h1FC6;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic who;
            who = k[0];
            tick();
            chk_val($sformatf("rr%0d_m0_gnt", k), m0_gnt, !who);
            chk_val($sformatf("rr%0d_m1_gnt", k), m1_gnt, who);
            chk_val($sformatf("rr%0d_praddr", k), PrAddr, who ? 30'h1FC6 : 30'h1FC2);
            tick();
            chk_val($sformatf("rr%0d_m0_done", k), m0_done, !who);
            chk_val($sformatf("rr%0d_m1_done", k), m1_done, who);
            tick();
            chk_val($sformatf("rr%0d_idle_gnt", k), {m0_gnt, m1_gnt}, 0);
        end
        m0_req = 1'b0; m1_req = 1'b0;

        // locked burst by M0 while M1 waits; rr currently favours M0
        m0_addr = 30'h1FC0; m1_addr = 30'h1FC4; m0_lock = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_val($sformatf("b%0d_m0_gnt", k), m0_gnt, 1);
            chk_val($sformatf("b%0d_m1_gnt", k), m1_gnt, 0);
            chk_val($sformatf("b%0d_praddr", k), PrAddr, 30'h1FC0 + 30'(k));
            tick();
            chk_val($sformatf("b%0d_m0_done", k), m0_done, 1);
            m0_addr = 30'h1FC0 + 30'(k + 1);
        end
        tick();
        chk_val("b_idle_gnt", {m0_gnt, m1_gnt}, 0);
        tick();
        chk_val("b_m1_gnt", m1_gnt, 1);
        chk_val("b_m0_gnt_after", m0_gnt, 0);
        chk_val("b_m1_praddr", PrAddr, 30'h1FC4);
        m0_req = 1'b0; m0_lock = 1'b0;
        tick();
        chk_val("b_m1_done", m1_done, 1);
        chk_val("b_m0_done_after", m0_done, 0);
        m1_req = 1'b0;
        tick();

        // out-of-range write
        PrRD = 32'hCAFE_F00D;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 30'h0000_0010; m0_wd = 32'hDEAD_BEEF;
        tick();
        chk_val("oor_prwe", PrWE, 0);
        chk_val("oor_praddr", PrAddr, 30'h10);
        chk_val("oor_err_acc", err, 0);
        tick();
        chk_val("oor_done", m0_done, 1);
        chk_val("oor_err", err, 1);
        chk_val("oor_rd", m0_rd, 0);
        m0_req = 1'b0; m0_we = 1'b0;
        tick();
        chk_val("oor_err_idle", err, 0);

        // reset asserted during ACCESS of a write
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 30'h1FC3; m0_wd = 32'h5555_AAAA;
        tick();
        chk_val("ra_prwe_pre", PrWE, 1);
        reset = 1'b0;
        #1;
        chk_val("ra_prwe_rst", PrWE, 0);
        chk_val("ra_gnt_rst", m0_gnt, 0);
        m0_req = 1'b0; m0_we = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_val($sformatf("ra%0d_prwe", k), PrWE, 0);
            chk_val($sformatf("ra%0d_done", k), m0_done, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
